line_mem_mp: RTL and testbench
==============================

# line_mem_mp

Multi-port, cache-line-granular backing memory model with programmable request and response delays. Up to NUM_PORTS cache controllers (I-cache, D-cache, ...) share one line array. Each port uses the mem_req_t / mem_resp_t handshake, and arbitration between ports is round-robin. It replaces the single-port, fixed-delay memory behind the L1 caches.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesting cache ports (≥1)
- LINE_WIDTH, 128, line width in bits (power of two, ≥32)
- ADDR_WIDTH, 32, byte-address width
- DEPTH, 8192, number of lines in the array (power of two)
- REQ_DELAY, 5, cycles from accept to array access (≥1)
- RESP_DELAY, 5, cycles from array access to response (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_PORTS  per-port request valid, held until that port's resp_ready
- req_rw  in  NUM_PORTS  per-port 1 = write line, 0 = read line
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port byte address; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_PORTS*LINE_WIDTH  per-port write line, packed the same way
- resp_ready  out  NUM_PORTS  one-cycle completion pulse to the granted port
- resp_addr  out  ADDR_WIDTH  address of the completed request
- resp_data  out  LINE_WIDTH  read line (read) or written line (write)
- busy  out  1  high in any state other than IDLE

## Operation
- OFFSET = log2(LINE_WIDTH/8).
- Line index = addr[OFFSET +: log2(DEPTH)]. Offset bits and higher bits are ignored, so out-of-range addresses alias (wrap).
- One transaction is outstanding at a time. Other requesters wait with valid held.
- FSM states: IDLE, REQ_WAIT, RESP_WAIT, DONE.
- IDLE:
  - If any req_valid is high, grant one port.
  - Latch the grant index, rw, addr and data.
  - cnt ← REQ_DELAY-1; go to REQ_WAIT.
- REQ_WAIT:
  - While cnt≠0, decrement cnt.
  - When cnt=0, perform the access: a write stores the latched line and copies it into the response buffer; a read copies array[index] into the response buffer.
  - cnt ← RESP_DELAY-1; go to RESP_WAIT.
- RESP_WAIT:
  - Decrement cnt to 0, then go to DONE.
  - Registered outputs are loaded on that edge: resp_ready[grant]=1, resp_data = buffer, resp_addr = latched addr.
- DONE:
  - Exactly one cycle; all outputs hold their values.
  - Next edge: go to IDLE and clear resp_ready.
- Requester contract: a port samples resp_ready at the edge leaving DONE and deasserts valid on that same edge. IDLE therefore never re-accepts a completed request.
- Grant pointer:
  - Reset value 0.
  - The port search starts at the pointer and goes upward, wrapping modulo NUM_PORTS.
  - After a grant to port g, pointer ← (g+1) mod NUM_PORTS.
- req_valid changing on a non-granted port during a transaction has no effect until the next IDLE.
- The granted port's inputs are ignored after the accept edge.

## Timing
- Reset values: resp_ready=0, resp_data=0, resp_addr=0, busy=0, state=IDLE, grant pointer=0, cnt=0.
- Array contents are not reset.
- Latency: with the accept at edge E0, resp_ready is high in the cycle following edge E0+REQ_DELAY+RESP_DELAY.
- Default latency is 10 cycles; minimum is 2 (both delays 1).
- Throughput: one transaction every REQ_DELAY+RESP_DELAY+2 cycles.
- A write is visible to a read accepted afterwards. A read accepted in the IDLE cycle right after a write's DONE returns the new data.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with outputs at their reset values.
  - A write is performed only if the access edge has already occurred.

## Configuration
- MEM_RR_ARB_EN defined: round-robin arbitration as above.
- Undefined: fixed priority, where the lowest-indexed valid port always wins and the grant pointer is not implemented.
- Latency and handshake are identical in both modes.

## Test plan
- Single write then read on port 0: write 0x000...DEADBEEF to addr 0x4000, then read 0x4000. The read returns the same line, and resp_ready is high exactly 10 cycles after each accept.
- Offset/alias check, DEPTH=8192, LINE_WIDTH=128: write line A to 0x4004, then read 0x4000 → A. Read 0x4000+(8192<<4) → A (wrap).
- Contention, MEM_RR_ARB_EN defined: ports 0 and 1 both hold valid from reset. Grants go 0,1,0,1, and each port receives resp_ready on alternate transactions.
- Contention, MEM_RR_ARB_EN undefined: port 0 re-requests immediately each time. Port 1 is never granted while port 0 is valid; after port 0 drops valid, port 1 completes 10 cycles after its accept.
- Delay corners: REQ_DELAY=1, RESP_DELAY=1. A read has resp_ready high 2 cycles after accept, and busy is high for exactly 3 cycles.
- Reset mid-operation: assert reset 2 cycles after a write accept, then read the same line. The old data is returned, and all outputs are 0 while reset is high.

Source files
------------

// File: rtl/line_mem_mp.sv
// ---------------------------------------------------------------------------
// line_mem_mp
//   Cache-line-granular backing memory shared by NUM_PORTS cache controllers.
//   Only one transaction is in flight at a time. Its timing is set by
//   REQ_DELAY (from accept to the array access) and RESP_DELAY (from the
//   array access to the response).
//
//   Arbitration between ports:
//     MEM_RR_ARB_EN defined   : round-robin. The search starts at a grant
//                               pointer, and the pointer moves to the port
//                               after the one just granted.
//     MEM_RR_ARB_EN undefined : fixed priority. The lowest-indexed valid port
//                               wins.
//
// Ports
//   clk, reset  : clock; asynchronous active-high reset
//   req_valid   : per-port request valid, held until that port's resp_ready
//   req_rw      : per-port 1 = write line, 0 = read line
//   req_addr    : per-port byte address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data    : per-port write line, port p at [p*LINE_WIDTH +: LINE_WIDTH]
//   resp_ready  : one-cycle completion pulse to the granted port
//   resp_addr   : address of the completed request
//   resp_data   : line read (read) or line written (write)
//   busy        : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module line_mem_mp #(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8192,
    parameter int REQ_DELAY  = 5,
    parameter int RESP_DELAY = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_rw,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_data,
    output logic [NUM_PORTS-1:0]            resp_ready,
    output logic [ADDR_WIDTH-1:0]           resp_addr,
    output logic [LINE_WIDTH-1:0]           resp_data,
    output logic                            busy
);
    localparam int OFFSET  = $clog2(LINE_WIDTH / 8);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DLY_MAX = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
    localparam int CNT_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam logic [CNT_W-1:0] REQ_LOAD  = CNT_W'(REQ_DELAY - 1);
    localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'(RESP_DELAY - 1);

    typedef enum logic [1:0] {IDLE, REQ_WAIT, RESP_WAIT, DONE} state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic [PORT_W-1:0]     grant_reg;
    logic                  rw_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LINE_WIDTH-1:0] data_reg;
    logic [LINE_WIDTH-1:0] buf_reg;
    logic [NUM_PORTS-1:0]  resp_ready_reg;
    logic [ADDR_WIDTH-1:0] resp_addr_reg;
    logic [LINE_WIDTH-1:0] resp_data_reg;

    logic                  grant_found;
    logic [PORT_W-1:0]     grant_idx;
    logic [NUM_PORTS-1:0]  grant_onehot;
    logic                  accept_en, access_en, finish_en, clear_en, count_en;
    logic [IDX_W-1:0]      line_idx;

    logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
    logic [LINE_WIDTH-1:0] port_data [NUM_PORTS];
    logic [LINE_WIDTH-1:0] mem [DEPTH];

    // Unpack the flat per-port buses and build the response one-hot.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign port_addr[gi]    = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_data[gi]    = req_data[gi*LINE_WIDTH +: LINE_WIDTH];
        assign grant_onehot[gi] = (grant_reg == PORT_W'(gi));
    end

    // Offset bits and bits above the index are dropped, so large addresses wrap.
    assign line_idx = addr_reg[OFFSET +: IDX_W];

`ifdef MEM_RR_ARB_EN
    logic [PORT_W-1:0] ptr_reg;
    int                cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (int'(ptr_reg) + i) % NUM_PORTS;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PORT_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (accept_en) begin
            ptr_reg <= PORT_W'((int'(grant_idx) + 1) % NUM_PORTS);
        end
    end
`else
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = PORT_W'(i);
            end
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (grant_found)      state_next = REQ_WAIT;
            REQ_WAIT:  if (cnt_reg == '0)    state_next = RESP_WAIT;
            RESP_WAIT: if (cnt_reg == '0)    state_next = DONE;
            DONE:                            state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // FSM outputs: busy flag and datapath strobes
    always_comb begin
        busy      = (state_reg != IDLE);
        accept_en = (state_reg == IDLE) && grant_found;
        access_en = (state_reg == REQ_WAIT) && (cnt_reg == '0);
        finish_en = (state_reg == RESP_WAIT) && (cnt_reg == '0);
        clear_en  = (state_reg == DONE);
        count_en  = ((state_reg == REQ_WAIT) || (state_reg == RESP_WAIT)) && (cnt_reg != '0);
    end

    // Request latch, delay counter and registered response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg        <= '0;
            grant_reg      <= '0;
            rw_reg         <= 1'b0;
            addr_reg       <= '0;
            data_reg       <= '0;
            resp_ready_reg <= '0;
            resp_addr_reg  <= '0;
            resp_data_reg  <= '0;
        end else begin
            if (accept_en) begin
                grant_reg <= grant_idx;
                rw_reg    <= req_rw[grant_idx];
                addr_reg  <= port_addr[grant_idx];
                data_reg  <= port_data[grant_idx];
                cnt_reg   <= REQ_LOAD;
            end else if (access_en) begin
                cnt_reg   <= RESP_LOAD;
            end else if (count_en) begin
                cnt_reg   <= cnt_reg - CNT_W'(1);
            end

            if (finish_en) begin
                resp_ready_reg <= grant_onehot;
                resp_addr_reg  <= addr_reg;
                resp_data_reg  <= buf_reg;
            end else if (clear_en) begin
                resp_ready_reg <= '0;
            end
        end
    end

    // Line array with registered read. There is no reset on this path. An
    // asserted reset forces IDLE, so access_en stays low and no write occurs.
    always_ff @(posedge clk) begin
        if (access_en) begin
            if (rw_reg) begin
                mem[line_idx] <= data_reg;
                buf_reg       <= data_reg;
            end else begin
                buf_reg       <= mem[line_idx];
            end
        end
    end

    assign resp_ready = resp_ready_reg;
    assign resp_addr  = resp_addr_reg;
    assign resp_data  = resp_data_reg;

endmodule

// File: tb/tb_line_mem_mp.sv
// ---------------------------------------------------------------------------
// tb_line_mem_mp
//   Bench for line_mem_mp. The main instance uses the default parameters. A
//   second instance uses both delays set to 1 for the minimum-latency corner.
//   When a request is driven, its expected grant (port and due cycle) and its
//   expected response line are queued. They are popped and compared when the
//   DUT pulses resp_ready.
// ---------------------------------------------------------------------------
module tb_line_mem_mp;
    localparam int NP  = 2;
    localparam int AW  = 32;
    localparam int LW  = 128;
    localparam int LAT = 10;    // main instance: REQ_DELAY + RESP_DELAY
    localparam int GAP = 12;    // main instance: back-to-back transaction spacing

    typedef struct { logic rw; logic [AW-1:0] addr; logic [LW-1:0] data; logic [LW-1:0] exp; } txn_t;
    typedef struct { int port; int due; } grant_t;
    typedef struct { logic [AW-1:0] addr; logic [LW-1:0] data; } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NP-1:0]     req_valid, req_rw;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*LW-1:0]  req_data;
    logic [NP-1:0]     resp_ready;
    logic [AW-1:0]     resp_addr;
    logic [LW-1:0]     resp_data;
    logic              busy;

    logic [NP-1:0]     f_req_valid, f_req_rw;
    logic [NP*AW-1:0]  f_req_addr;
    logic [NP*LW-1:0]  f_req_data;
    logic [NP-1:0]     f_resp_ready;
    logic [AW-1:0]     f_resp_addr;
    logic [LW-1:0]     f_resp_data;
    logic              f_busy;

    line_mem_mp #(
        .NUM_PORTS(NP), .LINE_WIDTH(LW), .ADDR_WIDTH(AW),
        .DEPTH(8192), .REQ_DELAY(5), .RESP_DELAY(5)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .resp_ready(resp_ready), .resp_addr(resp_addr), .resp_data(resp_data), .busy(busy)
    );

    line_mem_mp #(
        .NUM_PORTS(NP), .LINE_WIDTH(LW), .ADDR_WIDTH(AW),
        .DEPTH(16), .REQ_DELAY(1), .RESP_DELAY(1)
    ) dut_fast (
        .clk(clk), .reset(reset),
        .req_valid(f_req_valid), .req_rw(f_req_rw), .req_addr(f_req_addr), .req_data(f_req_data),
        .resp_ready(f_resp_ready), .resp_addr(f_resp_addr), .resp_data(f_resp_data), .busy(f_busy)
    );

    int      total = 0;
    int      bad   = 0;
    int      cyc   = 0;

    txn_t    tq0[$], tq1[$];
    int      order_q[$];
    grant_t  gq[$];
    resp_t   eq0[$], eq1[$];

    // values sampled on the falling edge by tick()
    int            s_cyc;
    logic [NP-1:0] s_rr, f_s_rr;
    logic          s_busy, f_s_busy;
    logic [AW-1:0] s_addr, f_s_addr;
    logic [LW-1:0] s_data, f_s_data;

    task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic rw, input logic [AW-1:0] addr,
                                input logic [LW-1:0] data, input logic [LW-1:0] exp);
        txn_t t;
        t.rw = rw; t.addr = addr; t.data = data; t.exp = exp;
        return t;
    endfunction

    function automatic logic [LW-1:0] cdata(input int p, input int j);
        logic [31:0] w;
        w = 32'hA5A5_0000 + 32'(p * 256 + j);
        return {w, ~w, w ^ 32'h5A5A_5A5A, 32'(j * 7 + 1)};
    endfunction

    // One clock: sample and score outputs on the falling edge, then return
    // just after the next rising edge, ready for new input values.
    task automatic tick();
        grant_t g;
        resp_t  e;
        @(negedge clk);
        s_cyc  = cyc;
        s_rr   = resp_ready;   s_busy   = busy;   s_addr   = resp_addr;   s_data   = resp_data;
        f_s_rr = f_resp_ready; f_s_busy = f_busy; f_s_addr = f_resp_addr; f_s_data = f_resp_data;
        if (resp_ready != '0) begin
            $display("resp cyc=%0d ready=%b addr=%h data=%h", cyc, resp_ready, resp_addr, resp_data);
            if (gq.size() == 0) begin
                check_val("unexpected_resp", LW'(resp_ready), '0);
            end else begin
                g = gq.pop_front();
                check_val("grant_port", LW'(resp_ready), LW'(1) << g.port);
                check_val("latency", LW'(cyc), LW'(g.due));
                check_val("busy_at_resp", LW'(busy), LW'(1));
                if (g.port == 0 && eq0.size() > 0) begin
                    e = eq0.pop_front();
                    check_val("resp_addr", LW'(resp_addr), LW'(e.addr));
                    check_val("resp_data", resp_data, e.data);
                end else if (g.port == 1 && eq1.size() > 0) begin
                    e = eq1.pop_front();
                    check_val("resp_addr", LW'(resp_addr), LW'(e.addr));
                    check_val("resp_data", resp_data, e.data);
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic present(input int p, input txn_t t);
        resp_t e;
        req_valid[p]           = 1'b1;
        req_rw[p]              = t.rw;
        req_addr[p*AW +: AW]   = t.addr;
        req_data[p*LW +: LW]   = t.data;
        e.addr = t.addr;
        e.data = t.rw ? t.data : t.exp;
        if (p == 0) eq0.push_back(e);
        else        eq1.push_back(e);
    endtask

    // Runs the per-port transaction lists. Each port presents its next request
    // on the edge where it sees its own resp_ready, so back-to-back
    // transactions start GAP cycles apart. order_q holds the expected grant order.
    task automatic run_ports();
        grant_t g;
        int     n0, n1, i0, i1, due;
        bit     done;
        n0 = tq0.size(); n1 = tq1.size(); i0 = 0; i1 = 0;
        due = cyc + 1 + LAT;
        foreach (order_q[k]) begin
            g.port = order_q[k];
            g.due  = due;
            gq.push_back(g);
            due += GAP;
        end
        if (n0 > 0) present(0, tq0[0]);
        if (n1 > 0) present(1, tq1[0]);
        done = (n0 == 0) && (n1 == 0);
        for (int c = 0; c < 400 && !done; c++) begin
            tick();
            if (s_rr[0] && i0 < n0) begin
                i0++;
                if (i0 < n0) present(0, tq0[i0]);
                else         req_valid[0] = 1'b0;
            end
            if (s_rr[1] && i1 < n1) begin
                i1++;
                if (i1 < n1) present(1, tq1[i1]);
                else         req_valid[1] = 1'b0;
            end
            done = (i0 >= n0) && (i1 >= n1);
        end
        check_val("run_complete", LW'(done), LW'(1));
        req_valid = '0;
        tq0.delete(); tq1.delete(); order_q.delete();
    endtask

    // Single transaction on port 0 of the minimum-delay instance.
    task automatic fast_txn(input string tag, input logic rw, input logic [AW-1:0] addr,
                            input logic [LW-1:0] data, input logic [LW-1:0] exp);
        int            start, rdy, nbusy;
        logic [LW-1:0] got;
        logic [AW-1:0] got_addr;
        start = cyc; rdy = -1; nbusy = 0; got = '0; got_addr = '0;
        f_req_valid[0]    = 1'b1;
        f_req_rw[0]       = rw;
        f_req_addr[AW-1:0] = addr;
        f_req_data[LW-1:0] = data;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (f_s_busy) nbusy++;
            if (f_s_rr[0] && rdy < 0) begin
                rdy      = s_cyc;
                got      = f_s_data;
                got_addr = f_s_addr;
                f_req_valid[0] = 1'b0;
            end
        end
        f_req_valid = '0;
        $display("fast %s start=%0d ready_cyc=%0d busy_cycles=%0d data=%h", tag, start, rdy, nbusy, got);
        check_val({tag, "_latency"}, LW'(rdy), LW'(start + 3));
        check_val({tag, "_busy_cycles"}, LW'(nbusy), LW'(3));
        check_val({tag, "_addr"}, LW'(got_addr), LW'(addr));
        check_val({tag, "_data"}, got, exp);
    endtask

    initial begin
        logic [LW-1:0] line_beef, line_a, line_new, line_f;
        line_beef = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
        line_a    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        line_new  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        line_f    = 128'hCAFE_F00D_0BAD_BEEF_1234_5678_9ABC_DEF0;

        reset = 1'b1;
        req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0;
        f_req_valid = '0; f_req_rw = '0; f_req_addr = '0; f_req_data = '0;

        // reset state
        tick(); tick();
        check_val("rst_resp_ready", LW'(s_rr), '0);
        check_val("rst_busy", LW'(s_busy), '0);
        check_val("rst_resp_addr", LW'(s_addr), '0);
        check_val("rst_resp_data", s_data, '0);
        check_val("rst_fast_busy", LW'(f_s_busy), '0);
        reset = 1'b0;

        // contention: both ports request continuously from reset (writes)
        for (int j = 0; j < 3; j++) begin
            tq0.push_back(mk(1'b1, 32'h0001_0000 + 32'(j * 16), cdata(0, j), '0));
            tq1.push_back(mk(1'b1, 32'h0001_0100 + 32'(j * 16), cdata(1, j), '0));
        end
`ifdef MEM_RR_ARB_EN
        order_q = '{0, 1, 0, 1, 0, 1};
`else
        order_q = '{0, 0, 0, 1, 1, 1};
`endif
        run_ports();

        // port 1 reads a line written by port 0
        tq1.push_back(mk(1'b0, 32'h0001_0010, '0, cdata(0, 1)));
        order_q = '{1};
        run_ports();

        // write then read on port 0; the read is accepted in the IDLE right after DONE
        tq0.push_back(mk(1'b1, 32'h0000_4000, line_beef, '0));
        tq0.push_back(mk(1'b0, 32'h0000_4000, '0, line_beef));
        order_q = '{0, 0};
        run_ports();

        // reset two cycles after a write accept, before its access edge
        present(0, mk(1'b1, 32'h0000_4000, line_new, '0));
        tick(); tick(); tick();
        reset = 1'b1;
        req_valid = '0;
        eq0.delete(); eq1.delete(); gq.delete();
        tick();
        check_val("midrst_resp_ready", LW'(s_rr), '0);
        check_val("midrst_busy", LW'(s_busy), '0);
        check_val("midrst_resp_addr", LW'(s_addr), '0);
        check_val("midrst_resp_data", s_data, '0);
        tick();
        reset = 1'b0;

        // old data survives, then the offset/alias checks
        tq0.push_back(mk(1'b0, 32'h0000_4000, '0, line_beef));
        tq0.push_back(mk(1'b1, 32'h0000_4004, line_a, '0));
        tq0.push_back(mk(1'b0, 32'h0000_4000, '0, line_a));
        tq0.push_back(mk(1'b0, 32'h0002_4000, '0, line_a));
        order_q = '{0, 0, 0, 0};
        run_ports();

        // minimum delay corner
        fast_txn("fast_wr", 1'b1, 32'h0000_0030, line_f, line_f);
        fast_txn("fast_rd", 1'b0, 32'h0000_0030, '0, line_f);

        tick(); tick();
        check_val("scoreboard_drain", LW'(gq.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
